// File: rtl/bip_accumulator_stage.sv
`default_nettype none
// ============================================================================
//  Module   : bip_accumulator_stage
//  Brief    : BIP accumulator datapath stage. Stage 1 captures the operand,
//             the memory word and the control fields; stage 2 runs the
//             add/sub ALU, updates the accumulator and tracks a sticky
//             signed-overflow flag. o_acc doubles as memory write data.
//  Revision : 1.0 - initial release
// ============================================================================
module bip_accumulator_stage #(
   parameter int NB_DATA  = 16,
   parameter int NB_SEL_A = 2
) (
   input  logic                i_clock,
   input  logic                i_reset,
   input  logic                i_valid,
   input  logic [NB_DATA-1:0]  i_extended_data,
   input  logic [NB_DATA-1:0]  i_mem_data,
   input  logic [NB_SEL_A-1:0] i_sel_a,
   input  logic                i_sel_b,
   input  logic                i_op,
   input  logic                i_wr_acc,
   input  logic                i_clr_ovf,
   output logic [NB_DATA-1:0]  o_acc,
   output logic                o_valid,
   output logic                o_overflow
);

   // Accumulator source encodings
   localparam logic [NB_SEL_A-1:0] c_SEL_MEM  = NB_SEL_A'(0);
   localparam logic [NB_SEL_A-1:0] c_SEL_IMM  = NB_SEL_A'(1);
   localparam logic [NB_SEL_A-1:0] c_SEL_ALU  = NB_SEL_A'(2);

   localparam int c_MSB = NB_DATA - 1;

   // Stage-1 capture registers
   logic [NB_DATA-1:0]  s1_imm_q;
   logic [NB_DATA-1:0]  s1_mem_q;
   logic [NB_SEL_A-1:0] s1_sel_a_q;
   logic                s1_sel_b_q;
   logic                s1_op_q;
   logic                s1_wr_q;
   logic                s1_valid_q;

   // Stage-2 architectural state
   logic [NB_DATA-1:0]  acc_q, acc_d;
   logic                ovf_q, ovf_d;
   logic                valid_q;

   // Stage-2 combinational terms
   logic [NB_DATA-1:0]  w_operand_b;
   logic [NB_DATA-1:0]  w_alu;
   logic                w_alu_ovf;
   logic                w_exec;
   logic                w_ovf_set;

   // Stage 1: capture operands and controls when an operation is presented;
   // data fields hold when idle, only the valid bit drops.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         s1_imm_q   <= '0;
         s1_mem_q   <= '0;
         s1_sel_a_q <= '0;
         s1_sel_b_q <= 1'b0;
         s1_op_q    <= 1'b0;
         s1_wr_q    <= 1'b0;
         s1_valid_q <= 1'b0;
      end else begin
         s1_valid_q <= i_valid;
         if (i_valid) begin
            s1_imm_q   <= i_extended_data;
            s1_mem_q   <= i_mem_data;
            s1_sel_a_q <= i_sel_a;
            s1_sel_b_q <= i_sel_b;
            s1_op_q    <= i_op;
            s1_wr_q    <= i_wr_acc;
         end
      end
   end

   // Stage 2: ALU on the live accumulator, next-value select, overflow update
   always_comb begin
      w_operand_b = s1_sel_b_q ? s1_imm_q : s1_mem_q;
      w_alu       = s1_op_q ? (acc_q - w_operand_b) : (acc_q + w_operand_b);

      // Add overflows when both operands share a sign the result lacks;
      // subtract overflows when acc and B differ and the result leaves acc's sign.
      if (s1_op_q) begin
         w_alu_ovf = (acc_q[c_MSB] != w_operand_b[c_MSB]) &&
                     (w_alu[c_MSB] != acc_q[c_MSB]);
      end else begin
         w_alu_ovf = (acc_q[c_MSB] == w_operand_b[c_MSB]) &&
                     (w_alu[c_MSB] != acc_q[c_MSB]);
      end

      w_exec    = s1_valid_q & s1_wr_q;
      acc_d     = acc_q;
      w_ovf_set = 1'b0;

      if (w_exec) begin
         case (s1_sel_a_q)
            c_SEL_MEM: acc_d = s1_mem_q;
            c_SEL_IMM: acc_d = s1_imm_q;
            c_SEL_ALU: begin
               acc_d     = w_alu;
               w_ovf_set = w_alu_ovf;
            end
            default:   acc_d = acc_q;
         endcase
      end

      // A new overflow in the same cycle as a clear leaves the flag set.
      ovf_d = w_ovf_set | (ovf_q & ~i_clr_ovf);
   end

   // Stage 2 state: accumulator, sticky overflow, completion pulse
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         acc_q   <= '0;
         ovf_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         ovf_q   <= ovf_d;
         valid_q <= s1_valid_q;
      end
   end

   assign o_acc      = acc_q;
   assign o_valid    = valid_q;
   assign o_overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_bip_accumulator_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bip_accumulator_stage
//  Brief    : Self-checking bench for bip_accumulator_stage: directed
//             scenarios followed by random operations against an
//             integer-arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bip_accumulator_stage;

   localparam int NB_DATA  = 16;
   localparam int NB_SEL_A = 2;

   logic                clk = 1'b0;
   logic                i_reset = 1'b0;
   logic                i_valid = 1'b0;
   logic [NB_DATA-1:0]  i_extended_data = '0;
   logic [NB_DATA-1:0]  i_mem_data = '0;
   logic [NB_SEL_A-1:0] i_sel_a = '0;
   logic                i_sel_b = 1'b0;
   logic                i_op = 1'b0;
   logic                i_wr_acc = 1'b0;
   logic                i_clr_ovf = 1'b0;
   logic [NB_DATA-1:0]  o_acc;
   logic                o_valid;
   logic                o_overflow;

   int n_checks = 0;
   int n_errors = 0;

   bip_accumulator_stage #(.NB_DATA(NB_DATA), .NB_SEL_A(NB_SEL_A)) u_dut (
      .i_clock         (clk),
      .i_reset         (i_reset),
      .i_valid         (i_valid),
      .i_extended_data (i_extended_data),
      .i_mem_data      (i_mem_data),
      .i_sel_a         (i_sel_a),
      .i_sel_b         (i_sel_b),
      .i_op            (i_op),
      .i_wr_acc        (i_wr_acc),
      .i_clr_ovf       (i_clr_ovf),
      .o_acc           (o_acc),
      .o_valid         (o_valid),
      .o_overflow      (o_overflow)
   );

   always #5 clk = ~clk;

   // Reference model: an operation accepted at one edge takes effect at the next.
   typedef struct {
      logic            valid;
      logic [15:0]     imm;
      logic [15:0]     mem;
      logic [1:0]      sel_a;
      logic            sel_b;
      logic            op;
      logic            wr;
   } op_t;

   op_t         pend;
   logic [15:0] m_acc;
   logic        m_ovf;
   logic        m_vout;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      pend   = '{valid: 1'b0, imm: '0, mem: '0, sel_a: '0, sel_b: 1'b0, op: 1'b0, wr: 1'b0};
      m_acc  = '0;
      m_ovf  = 1'b0;
      m_vout = 1'b0;
   endtask

   task automatic model_edge();
      int a, b, r;
      logic ovf_now;
      ovf_now = 1'b0;
      if (pend.valid && pend.wr) begin
         case (pend.sel_a)
            2'd0: m_acc = pend.mem;
            2'd1: m_acc = pend.imm;
            2'd2: begin
               a = int'($signed(m_acc));
               b = int'($signed(pend.sel_b ? pend.imm : pend.mem));
               r = pend.op ? a - b : a + b;
               ovf_now = (r > 32767) || (r < -32768);
               m_acc = r[15:0];
            end
            default: ;
         endcase
      end
      m_ovf  = ovf_now || (m_ovf && !i_clr_ovf);
      m_vout = pend.valid;
      pend.valid = i_valid;
      if (i_valid) begin
         pend.imm   = i_extended_data;
         pend.mem   = i_mem_data;
         pend.sel_a = i_sel_a;
         pend.sel_b = i_sel_b;
         pend.op    = i_op;
         pend.wr    = i_wr_acc;
      end
   endtask

   // One clock: update the model at the edge, then compare shortly after.
   task automatic tick(input string tag);
      @(posedge clk);
      if (i_reset) model_reset();
      else model_edge();
      #1;
      check({tag, ".acc"}, 32'(o_acc), 32'(m_acc));
      check({tag, ".valid"}, 32'(o_valid), 32'(m_vout));
      check({tag, ".ovf"}, 32'(o_overflow), 32'(m_ovf));
   endtask

   task automatic drive(input logic v, input logic [15:0] imm, input logic [15:0] mem,
                        input logic [1:0] sa, input logic sb, input logic op,
                        input logic wr, input logic clr);
      i_valid = v; i_extended_data = imm; i_mem_data = mem;
      i_sel_a = sa; i_sel_b = sb; i_op = op; i_wr_acc = wr; i_clr_ovf = clr;
   endtask

   task automatic idle();
      drive(1'b0, '0, '0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      model_reset();

      // Async reset asserted mid-cycle
      @(posedge clk); #2;
      i_reset = 1'b1; #1;
      check("rst.acc", 32'(o_acc), 32'h0);
      check("rst.valid", 32'(o_valid), 32'h0);
      check("rst.ovf", 32'(o_overflow), 32'h0);
      tick("rst_hold");
      #2 i_reset = 1'b0;
      for (int i = 0; i < 5; i++) tick("idle");

      // Load immediate -25
      drive(1'b1, 16'hFFE7, 16'h0, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0); tick("ldi_issue");
      check("ldi_lat.valid", 32'(o_valid), 32'h0);
      idle(); tick("ldi_done");
      check("ldi.acc", 32'(o_acc), 32'hFFE7);
      check("ldi.valid", 32'(o_valid), 32'h1);
      tick("ldi_after");
      check("ldi_pulse.valid", 32'(o_valid), 32'h0);

      // Back-to-back dependent chain: 25, +25, -10
      drive(1'b1, 16'd25, 16'h0, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0); tick("ch0");
      drive(1'b1, 16'd25, 16'h0, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0); tick("ch1");
      check("chain1.acc", 32'(o_acc), 32'd25);
      drive(1'b1, 16'h0, 16'd10, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0); tick("ch2");
      check("chain2.acc", 32'(o_acc), 32'd50);
      idle(); tick("ch3");
      check("chain3.acc", 32'(o_acc), 32'd40);
      check("chain3.valid", 32'(o_valid), 32'h1);
      tick("ch4");

      // Overflow set, clear, then clear coincident with a new overflow
      drive(1'b1, 16'h7FFF, 16'h0, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0); tick("ov0");
      drive(1'b1, 16'h0001, 16'h0, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0); tick("ov1");
      idle(); tick("ov2");
      check("ovf_add.acc", 32'(o_acc), 32'h8000);
      check("ovf_add.ovf", 32'(o_overflow), 32'h1);
      drive(1'b1, 16'h0000, 16'h0, 2'd2, 1'b1, 1'b0, 1'b1, 1'b1); tick("ov3");
      idle(); tick("ov4");
      check("ovf_clr.ovf", 32'(o_overflow), 32'h0);
      drive(1'b1, 16'h0001, 16'h0, 2'd2, 1'b1, 1'b1, 1'b1, 1'b0); tick("ov5");
      drive(1'b0, 16'h0, 16'h0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1); tick("ov6");
      check("ovf_setwins.acc", 32'(o_acc), 32'h7FFF);
      check("ovf_setwins.ovf", 32'(o_overflow), 32'h1);
      idle(); tick("ov7");

      // No-write, hold, and load from memory
      drive(1'b1, 16'h5555, 16'h6666, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0); tick("nw0");
      drive(1'b1, 16'h5555, 16'h6666, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0); tick("nw1");
      check("nowr.acc", 32'(o_acc), 32'h7FFF);
      check("nowr.valid", 32'(o_valid), 32'h1);
      drive(1'b1, 16'h0, 16'h1234, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0); tick("nw2");
      check("hold.acc", 32'(o_acc), 32'h7FFF);
      check("hold.valid", 32'(o_valid), 32'h1);
      idle(); tick("nw3");
      check("ldmem.acc", 32'(o_acc), 32'h1234);

      // Reset while an operation sits in stage 1
      drive(1'b1, 16'h00AA, 16'h0, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0); tick("rm0");
      idle();
      #2 i_reset = 1'b1; #1;
      check("rstmid.acc", 32'(o_acc), 32'h0);
      check("rstmid.ovf", 32'(o_overflow), 32'h0);
      tick("rm_hold");
      #2 i_reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick("rm_after");
         check("rstmid_nopulse.valid", 32'(o_valid), 32'h0);
         check("rstmid_nowrite.acc", 32'(o_acc), 32'h0);
      end

      // Random operations against the model
      for (int i = 0; i < 500; i++) begin
         logic [15:0] rimm, rmem;
         rimm = 16'($urandom);
         rmem = 16'($urandom);
         if ($urandom_range(0, 3) == 0) rimm = ($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h8000;
         drive($urandom_range(0, 3) != 0, rimm, rmem, 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom_range(0, 4) != 0, $urandom_range(0, 9) == 0);
         tick("rand");
      end
      idle();
      tick("drain0");
      tick("drain1");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   // Hard stop in case the stimulus process stalls
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
